// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and the forwarding-select rule for hazard_ctrl.
package hazard_pkg;
    typedef enum logic [1:0] {FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10} fwd_sel_t;
    typedef enum logic [1:0] {IDLE, WAIT, ERR} mem_state_t;

    // The M stage holds the newer value, so it wins over W.
    function automatic fwd_sel_t fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                         input logic [4:0] rd_w, input logic we_m,
                                         input logic we_w);
        return (we_m && rd_m != 5'd0 && rd_m == rs) ? FWD_M :
               (we_w && rd_w != 5'd0 && rd_w == rs) ? FWD_W : FWD_RF;
    endfunction
endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: tracks an outstanding data-memory access and raises a sticky error on timeout.
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic MemReqM,
    input  logic MemReadyM,
    output logic memStall,
    output logic MemErr
);
    localparam logic [7:0] TO = 8'(TIMEOUT);

    mem_state_t state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (MemReqM && !MemReadyM) begin
                state_d = WAIT;
                cnt_d   = 8'd1;
            end
            WAIT: if (MemReadyM) begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end else if (cnt_q == TO) begin
                state_d = ERR;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign memStall = (state_q == IDLE && MemReqM && !MemReadyM) ||
                      (state_q == WAIT && !MemReadyM) || state_q == ERR;
    assign MemErr   = state_q == ERR;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: forwarding, load-use and memory-wait stall/flush control.
// Define HAZARD_PERF_CNT_EN to build the saturating StallCnt/FlushCnt counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic        LoadE,
    input  logic        PCSrcE,
    input  logic        MemReqM,
    input  logic        MemReadyM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic        FlushW,
    output logic [1:0]  ForwardAE,
    output logic [1:0]  ForwardBE,
    output logic        MemErr,
    output logic [31:0] StallCnt,
    output logic [31:0] FlushCnt
);
    logic mem_stall, lw_stall;

    mem_wait_fsm #(.TIMEOUT(TIMEOUT)) u_mem (
        .clk      (clk),
        .reset    (reset),
        .MemReqM  (MemReqM),
        .MemReadyM(MemReadyM),
        .memStall (mem_stall),
        .MemErr   (MemErr)
    );

    assign ForwardAE = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW);
    assign ForwardBE = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW);
    assign lw_stall  = LoadE && RdE != 5'd0 && (RdE == Rs1D || RdE == Rs2D);

    // A memory stall freezes the whole pipe, so a taken branch waits in E until it clears.
    always_comb begin
        StallF = mem_stall || lw_stall;
        StallD = mem_stall || lw_stall;
        StallE = mem_stall;
        StallM = mem_stall;
        FlushW = mem_stall;
        FlushD = !mem_stall && PCSrcE;
        FlushE = !mem_stall && (lw_stall || PCSrcE);
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = (StallF && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
        flush_cnt_d = (FlushE && flush_cnt_q != '1) ? flush_cnt_q + 32'd1 : flush_cnt_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign StallCnt = stall_cnt_q;
    assign FlushCnt = flush_cnt_q;
`else
    assign StallCnt = '0;
    assign FlushCnt = '0;
`endif
endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum memory-wait cycles before error, range 1..255.
REQ-002 SHALL have port clk, input, 1 bit: clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-004 SHALL have ports Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, each input, 5 bits: register specifiers per stage.
REQ-005 SHALL have ports RegWriteM, RegWriteW, each input, 1 bit: writeback enables in M and W.
REQ-006 SHALL have port LoadE, input, 1 bit: instruction in E is a load (ResultSrcE bit 0).
REQ-007 SHALL have port PCSrcE, input, 1 bit: taken branch or jump resolved in E.
REQ-008 SHALL have ports MemReqM and MemReadyM, each input, 1 bit: data-memory access in M and its completion acknowledge.
REQ-009 SHALL have ports StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, each output, 1 bit: pipeline-register controls.
REQ-010 SHALL have ports ForwardAE and ForwardBE, each output, 2 bits: ALU operand source selects.
REQ-011 SHALL have port MemErr, output, 1 bit: sticky memory-timeout flag.
REQ-012 SHALL have ports StallCnt and FlushCnt, each output, 32 bits: performance counters.

Function
REQ-013 ForwardAE SHALL be 10 when RegWriteM, RdM!=0 and RdM==Rs1E; else 01 when RegWriteW, RdW!=0 and RdW==Rs1E; else 00; ForwardBE SHALL follow the same rules using Rs2E; both combinational.
REQ-014 lwStall SHALL equal LoadE && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
REQ-015 The memory FSM SHALL have states IDLE, WAIT and ERR.
REQ-016 From IDLE, MemReqM && !MemReadyM SHALL go to WAIT with the wait counter cleared to 1; otherwise stay in IDLE.
REQ-017 In WAIT, MemReadyM SHALL go to IDLE; else, if the counter equals TIMEOUT, SHALL go to ERR; else the counter SHALL increment.
REQ-018 ERR SHALL be left only by reset; MemErr SHALL be 1 exactly in ERR.
REQ-019 memStall SHALL equal (IDLE && MemReqM && !MemReadyM) || (WAIT && !MemReadyM) || ERR; in WAIT the cycle with MemReadyM=1 SHALL have no memStall.
REQ-020 When memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0.
REQ-021 When memStall=0: StallF=StallD=lwStall, StallE=StallM=FlushW=0, FlushD=PCSrcE, FlushE=lwStall||PCSrcE.
REQ-022 lwStall and PCSrcE together SHALL assert StallD and FlushD; the D register gives flush priority.
REQ-023 PCSrcE during memStall SHALL be held in E and flush only in the first cycle memStall deasserts.

Reset
REQ-024 Reset SHALL force IDLE, wait counter 0, MemErr 0 and both performance counters 0, including mid-WAIT or in ERR.
REQ-025 With reset asserted and all inputs 0, every output SHALL be 0.

Configuration
REQ-026 With HAZARD_PERF_CNT_EN defined, StallCnt SHALL increment in each cycle with StallF=1 and FlushCnt in each cycle with FlushE=1, both saturating at 0xFFFFFFFF.
REQ-027 Without HAZARD_PERF_CNT_EN, StallCnt and FlushCnt SHALL be present and tied to 0, with no counter flops.

Structure
REQ-028 Package hazard_pkg SHALL hold fwd_sel_t (FWD_RF=00, FWD_W=01, FWD_M=10) and mem_state_t (IDLE, WAIT, ERR).
REQ-029 The memory FSM and wait counter SHALL be sub-module mem_wait_fsm, outputting memStall and MemErr.

Verification
REQ-030 RdM=5, RegWriteM=1, RdW=5, RegWriteW=1, Rs1E=5 -> ForwardAE=10; with RdM=0 -> ForwardAE=01.
REQ-031 LoadE=1, RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle; RdE=0 -> no stall.
REQ-032 MemReqM=1, MemReadyM low for 3 cycles then high -> all four stalls and FlushW high for 3 cycles, low on the 4th, FSM back to IDLE.
REQ-033 TIMEOUT=4, MemReadyM never high -> ERR after 4 WAIT cycles, MemErr=1 and stalls held; reset -> IDLE, MemErr=0.
REQ-034 PCSrcE=1 during a 2-cycle memStall -> FlushD=FlushE=0 during the stall, both 1 in the following cycle.
REQ-035 HAZARD_PERF_CNT_EN defined, 10 stall cycles and 3 flush cycles -> StallCnt=10, FlushCnt=3; undefined -> both 0.
